// File: rtl/song_reader_pkg.sv
// Shared definitions for the song sequencer: widths, ROM field layout and FSM encoding.
package song_reader_pkg;

  localparam int ADDR_W = 7;
  localparam int SONG_W = 2;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int IDX_W  = ADDR_W - SONG_W;
  localparam int ROM_W  = NOTE_W + DUR_W;

  localparam int NOTE_LSB = DUR_W;
  localparam int DUR_LSB  = 0;

  localparam logic [DUR_W-1:0]  END_DUR   = '0;
  localparam logic [NOTE_W-1:0] REST_NOTE = '0;
  localparam logic [IDX_W-1:0]  LAST_IDX  = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_WAIT_DONE,
    ST_DONE
  } state_e;

  function automatic logic [NOTE_W-1:0] rom_note(input logic [ROM_W-1:0] word);
    return word[NOTE_LSB +: NOTE_W];
  endfunction

  function automatic logic [DUR_W-1:0] rom_dur(input logic [ROM_W-1:0] word);
    return word[DUR_LSB +: DUR_W];
  endfunction

endpackage

// File: rtl/song_reader_if.sv
// Control, ROM and note-player signals of the song sequencer; master = sequencer side.
interface song_reader_if;
  import song_reader_pkg::*;

  logic              play;
  logic [SONG_W-1:0] song;
  logic [ADDR_W-1:0] rom_addr;
  logic [ROM_W-1:0]  rom_dout;
  logic [NOTE_W-1:0] note;
  logic [DUR_W-1:0]  duration;
  logic              new_note;
  logic              note_done;
  logic              song_done;

  modport master (
    input  play, song, rom_dout, note_done,
    output rom_addr, note, duration, new_note, song_done
  );

  modport slave (
    output play, song, rom_dout, note_done,
    input  rom_addr, note, duration, new_note, song_done
  );

endinterface

// File: rtl/song_reader.sv
// Walks the selected song in ROM and hands each {note,duration} to the note player,
// pulsing song_done on an end marker or after the last slot of the song.
module song_reader
  import song_reader_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  song_reader_if.master bus
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic              new_note_q, new_note_d;
  logic              song_done_q, song_done_d;
  logic              song_changed;

  assign song_changed = (bus.song != song_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    song_d      = song_q;
    note_d      = note_q;
    dur_d       = dur_q;
    new_note_d  = 1'b0;
    song_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (bus.play) begin
          song_d  = bus.song;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (song_changed) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else if (bus.play) begin
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (song_changed) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else if (rom_dur(bus.rom_dout) == END_DUR) begin
          song_done_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          note_d     = rom_note(bus.rom_dout);
          dur_d      = rom_dur(bus.rom_dout);
          new_note_d = 1'b1;
          state_d    = ST_WAIT_DONE;
        end
      end

      // A note_done coinciding with new_note belongs to the previous note, so drop it.
      ST_WAIT_DONE: begin
        if (song_changed) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else if (bus.note_done && !new_note_q) begin
          if (idx_q == LAST_IDX) begin
            song_done_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end

      ST_DONE: begin
        if (!bus.play || song_changed) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      song_q      <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      song_q      <= song_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
    end
  end

  assign bus.rom_addr  = {song_q, idx_q};
  assign bus.note      = note_q;
  assign bus.duration  = dur_q;
  assign bus.new_note  = new_note_q;
  assign bus.song_done = song_done_q;

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader with a registered-read ROM model and hand-computed expectations.
module tb_song_reader;
  import song_reader_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  song_reader_if bus();

  song_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [ROM_W-1:0] rom [0:(1<<ADDR_W)-1];

  always @(posedge clk) bus.rom_dout <= rom[bus.rom_addr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic [SONG_W-1:0] s);
    @(negedge clk);
    bus.play = p;
    bus.song = s;
  endtask

  // note_done is dropped on the first sampled edge so every caller can leave it as a one-cycle pulse.
  task automatic waitEvent(input int maxCycles, output bit gotNote, output bit gotDone, output int cycles);
    gotNote = 1'b0;
    gotDone = 1'b0;
    cycles  = 0;
    while (!gotNote && !gotDone && cycles < maxCycles) begin
      @(negedge clk);
      bus.note_done = 1'b0;
      cycles++;
      gotNote = bus.new_note;
      gotDone = bus.song_done;
    end
  endtask

  task automatic countPulses(input int n, output int notes, output int dones);
    notes = 0;
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.note_done = 1'b0;
      if (bus.new_note)  notes++;
      if (bus.song_done) dones++;
    end
  endtask

  task automatic runSong(input bit start, input logic [SONG_W-1:0] s, output int notes, output bit done,
                         output logic [NOTE_W-1:0] lastNote, output logic [DUR_W-1:0] lastDur);
    bit gn, gd, pending;
    int cyc;
    notes    = 0;
    done     = 1'b0;
    lastNote = '0;
    lastDur  = '0;
    pending  = !start;
    if (start) applyStimulus(1'b1, s);
    for (int k = 0; k < 40; k++) begin
      if (pending) begin
        @(negedge clk);
        bus.note_done = 1'b1;
      end
      waitEvent(8, gn, gd, cyc);
      if (gn) begin
        notes++;
        lastNote = bus.note;
        lastDur  = bus.duration;
        pending  = 1'b1;
      end else if (gd) begin
        done = 1'b1;
        break;
      end else begin
        checkOutput("run_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit gn, gd, done;
    int cyc, nn, sd, notes;
    logic [NOTE_W-1:0] ln;
    logic [DUR_W-1:0]  ld;

    for (int a = 0; a < (1<<ADDR_W); a++)
      rom[a] = {NOTE_W'((a*5 + 3) % 64), DUR_W'((a % 9) + 1)};
    rom[0]   = {6'd49, 6'd12};
    rom[1]   = {6'd1,  6'd8};
    rom[27]  = {6'd50, 6'd3};
    rom[28]  = {6'd37, 6'd0};
    rom[32]  = {6'd35, 6'd36};
    rom[66]  = {6'd0,  6'd34};
    rom[67]  = {6'd20, 6'd5};
    rom[124] = {6'd9,  6'd20};
    rom[125] = {6'd5,  6'd0};

    bus.play      = 1'b0;
    bus.song      = '0;
    bus.note_done = 1'b0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_note", bus.note, 0);
    checkOutput("rst_duration", bus.duration, 0);
    checkOutput("rst_new_note", bus.new_note, 0);
    checkOutput("rst_song_done", bus.song_done, 0);
    checkOutput("rst_rom_addr", bus.rom_addr, 0);
    @(negedge clk);
    reset = 1'b0;

    // Song 0: first two notes with latency, then run to the end marker at address 28.
    applyStimulus(1'b1, 2'd0);
    waitEvent(8, gn, gd, cyc);
    checkOutput("s0_first_seen", gn, 1);
    checkOutput("s0_first_latency", cyc, 3);
    checkOutput("s0_first_note", bus.note, 49);
    checkOutput("s0_first_dur", bus.duration, 12);
    checkOutput("s0_first_addr", bus.rom_addr, 0);
    @(negedge clk);
    bus.note_done = 1'b1;
    waitEvent(8, gn, gd, cyc);
    checkOutput("s0_second_seen", gn, 1);
    checkOutput("s0_second_latency", cyc, 3);
    checkOutput("s0_second_note", bus.note, 1);
    checkOutput("s0_second_dur", bus.duration, 8);
    checkOutput("s0_second_addr", bus.rom_addr, 1);
    runSong(1'b0, 2'd0, notes, done, ln, ld);
    checkOutput("s0_total_notes", notes + 2, 28);
    checkOutput("s0_song_done", done, 1);
    checkOutput("s0_last_note", ln, 50);
    checkOutput("s0_last_dur", ld, 3);
    checkOutput("s0_hold_note", bus.note, 50);
    checkOutput("s0_hold_dur", bus.duration, 3);
    countPulses(5, nn, sd);
    checkOutput("s0_done_no_note", nn, 0);
    checkOutput("s0_done_single_pulse", sd, 0);
    checkOutput("s0_done_addr", bus.rom_addr, 28);
    applyStimulus(1'b0, 2'd0);
    countPulses(2, nn, sd);
    checkOutput("s0_idle_addr", bus.rom_addr, 0);

    // Song 1: first note, then switch song while waiting on note_done.
    applyStimulus(1'b1, 2'd1);
    waitEvent(8, gn, gd, cyc);
    checkOutput("s1_first_seen", gn, 1);
    checkOutput("s1_first_note", bus.note, 35);
    checkOutput("s1_first_dur", bus.duration, 36);
    applyStimulus(1'b0, 2'd0);
    countPulses(4, nn, sd);
    checkOutput("s1_switch_no_note", nn, 0);
    checkOutput("s1_switch_no_done", sd, 0);
    checkOutput("s1_switch_note_kept", bus.note, 35);
    checkOutput("s1_switch_idle_addr", bus.rom_addr, 32);

    // Song 2: rest at address 66, pause in FETCH, ignored note_done, reset mid-song.
    applyStimulus(1'b1, 2'd2);
    waitEvent(8, gn, gd, cyc);
    @(negedge clk);
    bus.note_done = 1'b1;
    waitEvent(8, gn, gd, cyc);
    @(negedge clk);
    bus.note_done = 1'b1;
    waitEvent(8, gn, gd, cyc);
    checkOutput("s2_rest_seen", gn, 1);
    checkOutput("s2_rest_note", bus.note, 32'(REST_NOTE));
    checkOutput("s2_rest_dur", bus.duration, 34);
    checkOutput("s2_rest_addr", bus.rom_addr, 66);
    applyStimulus(1'b0, 2'd2);
    @(negedge clk);
    bus.note_done = 1'b1;
    countPulses(5, nn, sd);
    checkOutput("s2_pause_no_note", nn, 0);
    checkOutput("s2_pause_addr", bus.rom_addr, 67);
    applyStimulus(1'b1, 2'd2);
    waitEvent(8, gn, gd, cyc);
    checkOutput("s2_resume_seen", gn, 1);
    checkOutput("s2_resume_note", bus.note, 20);
    checkOutput("s2_resume_dur", bus.duration, 5);
    bus.note_done = 1'b1;
    countPulses(5, nn, sd);
    checkOutput("s2_early_done_ignored", nn, 0);
    checkOutput("s2_early_done_addr", bus.rom_addr, 67);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_note", bus.note, 0);
    checkOutput("mid_rst_duration", bus.duration, 0);
    checkOutput("mid_rst_rom_addr", bus.rom_addr, 0);
    checkOutput("mid_rst_new_note", bus.new_note, 0);
    checkOutput("mid_rst_song_done", bus.song_done, 0);
    bus.play = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Song 3: marker at idx 29, then full 32 entries terminating after the last note_done.
    runSong(1'b1, 2'd3, notes, done, ln, ld);
    checkOutput("s3_marker_notes", notes, 29);
    checkOutput("s3_marker_done", done, 1);
    checkOutput("s3_marker_last_note", ln, 9);
    checkOutput("s3_marker_last_dur", ld, 20);
    checkOutput("s3_marker_addr", bus.rom_addr, 125);
    applyStimulus(1'b0, 2'd3);
    rom[125] = {6'd11, 6'd4};
    rom[126] = {6'd30, 6'd2};
    rom[127] = {6'd63, 6'd63};
    runSong(1'b1, 2'd3, notes, done, ln, ld);
    checkOutput("s3_full_notes", notes, 32);
    checkOutput("s3_full_done", done, 1);
    checkOutput("s3_full_last_note", ln, 63);
    checkOutput("s3_full_last_dur", ld, 63);
    checkOutput("s3_full_addr", bus.rom_addr, 127);
    countPulses(3, nn, sd);
    checkOutput("s3_full_hold_no_note", nn, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
